flash_arbiter: RTL
==================

FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 SHALL have parameter DUMMY_CYC, default 6, dummy clocks after the address (mode nibbles included).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum bytes per port-B transaction (1..256).
REQ-003 SHALL have port clk  in  1  SPI-domain clock; all logic on its rising edge; one clock only.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port a_req  in  1  CPU single-byte read request, level-held until a_valid.
REQ-006 SHALL have port a_addr  in  24  CPU flash byte address.
REQ-007 SHALL have ports a_valid  out  1 and a_data  out  8: one-cycle pulse with the byte read for port A.
REQ-008 SHALL have port b_req  in  1  background burst read request, held until b_done.
REQ-009 SHALL have ports b_addr  in  24 and b_len  in  9: burst start address and byte count (1..256).
REQ-010 SHALL have ports b_valid  out  1 and b_data  out  8: one pulse per port-B byte.
REQ-011 SHALL have port b_done  out  1  one-cycle pulse after the last byte of the burst.
REQ-012 SHALL have ports spi_ss  out  1, spi_clken  out  1, spi_out  out  4 and spi_in  in  4: chip-select active high, SCK gate, quad data out and quad data in.
REQ-013 SHALL have ports spi_oe0  out  1 (IO0 driven) and spi_oe123  out  1 (IO1..IO3 driven).

Function
REQ-014 SHALL use the states IDLE, CMD, ADDR, DUMMY, DATA and GAP; the state register SHALL be one-hot.
REQ-015 IDLE: if a_req=1, SHALL start a port-A transaction. Otherwise, if b_req=1 and the B remaining count is nonzero, SHALL start a port-B transaction. A has strict priority.
REQ-016 CMD: SHALL shift 0xEB MSB-first on spi_out[0] for 8 cycles; spi_oe0=1, spi_oe123=0.
REQ-017 ADDR: SHALL shift 6 address nibbles MSB-first on spi_out[3:0] for 6 cycles; spi_oe0=spi_oe123=1.
REQ-018 DUMMY: SHALL drive 4'hF on the first 2 cycles (mode bits), then release the bus; DUMMY lasts DUMMY_CYC cycles in total.
REQ-019 DATA: SHALL sample spi_in as the high nibble on the first cycle and the low nibble on the second; the assembled byte pulses the owner's valid on the cycle after the second nibble.
REQ-020 Port-A latency SHALL be fixed: a_valid asserts 8+6+DUMMY_CYC+2+1 cycles after the IDLE cycle that accepted a_req (23 with defaults).
REQ-021 spi_ss=1 and spi_clken=1 SHALL hold in CMD, ADDR, DUMMY and DATA only; in IDLE and GAP both are 0, with spi_oe0=spi_oe123=0.
REQ-022 A port-A transaction SHALL read exactly 1 byte and then enter GAP.
REQ-023 A port-B transaction SHALL read min(remaining, MAX_BURST) bytes consecutively in DATA, without re-sending command or address.
REQ-024 Preemption: if a_req=1 at a port-B byte boundary (after the low nibble), the controller SHALL end the B transaction after that byte and enter GAP; the B next-address and remaining count SHALL be kept.
REQ-025 GAP SHALL last exactly 2 cycles (tSHSL deselect time) and then return to IDLE.
REQ-026 B bookkeeping: on b_req rising while the B remaining count is 0, SHALL latch b_addr into the next-address register and b_len into the remaining count (b_len=0 SHALL be treated as 256).
REQ-027 Each B byte SHALL increment the next address (modulo 2^24, wrapping 0xFFFFFF to 0x000000) and decrement the remaining count.
REQ-028 b_done SHALL pulse on the cycle when the remaining count reaches 0; a new burst requires b_req to fall and then rise again.
REQ-029 If b_req drops mid-burst, the current transaction SHALL finish and then the remaining count is cleared with no b_done.
REQ-030 Simultaneous rise of a_req and b_req in IDLE SHALL be resolved as A first; B starts after A's GAP.
REQ-031 a_addr SHALL be captured in IDLE only; changes during a transaction have no effect.

Reset
REQ-032 Reset SHALL take effect asynchronously, including mid-transaction: state=IDLE; spi_ss, spi_clken, spi_oe0 and spi_oe123 = 0; spi_out=0.
REQ-033 During reset, a_valid, b_valid and b_done SHALL be 0; a_data and b_data SHALL be 0x00; the B remaining count SHALL be 0.
REQ-034 After reset, the first rising clk edge with reset=0 SHALL be able to accept a request.

Verification
REQ-035 Single A read: a_req with a_addr=0x123456 and flash model 0xA5 -> serial cmd EB, nibbles 1,2,3,4,5,6, a_valid with 0xA5 exactly 23 cycles later, spi_ss low for 2 cycles.
REQ-036 B burst: b_addr=0x0000F0 and b_len=20 -> two transactions of 16 and 4 bytes, addresses 0x0000F0 and 0x000100, 20 b_valid pulses, 1 b_done.
REQ-037 Preemption: a_req raised during B byte 5 -> B stops after byte 5; A byte delivered; B resumes at b_addr+5 with 15 bytes outstanding.
REQ-038 Wrap: b_addr=0xFFFFFE and b_len=4 -> byte addresses FFFFFE, FFFFFF, 000000 and 000001.
REQ-039 Reset asserted during ADDR -> outputs idle immediately; a later a_req completes normally with 23-cycle latency.
REQ-040 Simultaneous a_req and b_req from IDLE -> a_valid precedes the first b_valid; a 2-cycle GAP separates the transactions.

Source files
------------

// File: rtl/flash_arbiter.sv
// Two-port quad-SPI flash read arbiter: port A issues single-byte CPU reads with
// strict priority, port B streams background bursts split into MAX_BURST chunks.
module flash_arbiter #(
  parameter int DUMMY_CYC = 6,
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [23:0] a_addr,
  output logic        a_valid,
  output logic [7:0]  a_data,
  input  logic        b_req,
  input  logic [23:0] b_addr,
  input  logic [8:0]  b_len,
  output logic        b_valid,
  output logic [7:0]  b_data,
  output logic        b_done,
  output logic        spi_ss,
  output logic        spi_clken,
  output logic [3:0]  spi_out,
  input  logic [3:0]  spi_in,
  output logic        spi_oe0,
  output logic        spi_oe123
);

  localparam logic [7:0] CMD_BYTE   = 8'hEB;
  localparam logic [7:0] CMD_LAST   = 8'd7;
  localparam logic [7:0] ADDR_LAST  = 8'd5;
  localparam logic [7:0] MODE_CYC   = 8'd2;
  localparam logic [7:0] GAP_LAST   = 8'd1;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);
  localparam logic [8:0] BURST_MAX  = 9'(MAX_BURST);

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    CMD   = 6'b000010,
    ADDR  = 6'b000100,
    DUMMY = 6'b001000,
    DATA  = 6'b010000,
    GAP   = 6'b100000
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg;
  logic        owner_b_reg;
  logic [23:0] addr_reg;
  logic [8:0]  burst_left_reg;
  logic [3:0]  hi_nib_reg;
  logic        nib_lo_reg;
  logic        a_valid_reg, b_valid_reg, b_done_reg;
  logic [7:0]  a_data_reg, b_data_reg;
  logic [23:0] b_next_addr_reg;
  logic [8:0]  b_remain_reg;
  logic        b_req_d_reg;

  logic        start_a, start_b;
  logic        b_busy, b_byte;
  logic [8:0]  burst_len;

  assign start_a   = (state_reg == IDLE) && a_req;
  assign start_b   = (state_reg == IDLE) && !a_req && b_req && (b_remain_reg != 9'd0);
  assign burst_len = (b_remain_reg > BURST_MAX) ? BURST_MAX : b_remain_reg;
  assign b_busy    = owner_b_reg && (state_reg != IDLE) && (state_reg != GAP);
  assign b_byte    = (state_reg == DATA) && nib_lo_reg && owner_b_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Bus pins are decoded from registered state so they fall immediately on reset.
  always_comb begin
    state_next = state_reg;
    spi_ss     = 1'b0;
    spi_clken  = 1'b0;
    spi_out    = 4'h0;
    spi_oe0    = 1'b0;
    spi_oe123  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_a || start_b) state_next = CMD;
      end
      CMD: begin
        spi_ss    = 1'b1;
        spi_clken = 1'b1;
        spi_oe0   = 1'b1;
        spi_out   = {3'b000, CMD_BYTE[~cnt_reg[2:0]]};
        if (cnt_reg == CMD_LAST) state_next = ADDR;
      end
      ADDR: begin
        spi_ss    = 1'b1;
        spi_clken = 1'b1;
        spi_oe0   = 1'b1;
        spi_oe123 = 1'b1;
        spi_out   = addr_reg[23:20];
        if (cnt_reg == ADDR_LAST) state_next = DUMMY;
      end
      DUMMY: begin
        spi_ss    = 1'b1;
        spi_clken = 1'b1;
        if (cnt_reg < MODE_CYC) begin
          spi_out   = 4'hF;
          spi_oe0   = 1'b1;
          spi_oe123 = 1'b1;
        end
        if (cnt_reg == DUMMY_LAST) state_next = DATA;
      end
      DATA: begin
        spi_ss    = 1'b1;
        spi_clken = 1'b1;
        // Byte boundary: A always stops after one byte; B stops at chunk end or when A is waiting.
        if (nib_lo_reg && (!owner_b_reg || burst_left_reg == 9'd1 || a_req)) state_next = GAP;
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg        <= 8'd0;
      owner_b_reg    <= 1'b0;
      addr_reg       <= 24'd0;
      burst_left_reg <= 9'd0;
      hi_nib_reg     <= 4'h0;
      nib_lo_reg     <= 1'b0;
      a_valid_reg    <= 1'b0;
      a_data_reg     <= 8'h00;
      b_valid_reg    <= 1'b0;
      b_data_reg     <= 8'h00;
    end else begin
      a_valid_reg <= 1'b0;
      b_valid_reg <= 1'b0;
      cnt_reg     <= (state_next != state_reg) ? 8'd0 : cnt_reg + 8'd1;

      if (start_a || start_b) begin
        owner_b_reg    <= start_b;
        addr_reg       <= start_a ? a_addr : b_next_addr_reg;
        burst_left_reg <= start_a ? 9'd1 : burst_len;
      end

      if (state_reg == ADDR) begin
        addr_reg <= {addr_reg[19:0], 4'h0};
      end

      if (state_reg == DATA) begin
        if (!nib_lo_reg) begin
          hi_nib_reg <= spi_in;
          nib_lo_reg <= 1'b1;
        end else begin
          nib_lo_reg     <= 1'b0;
          burst_left_reg <= burst_left_reg - 9'd1;
          if (owner_b_reg) begin
            b_valid_reg <= 1'b1;
            b_data_reg  <= {hi_nib_reg, spi_in};
          end else begin
            a_valid_reg <= 1'b1;
            a_data_reg  <= {hi_nib_reg, spi_in};
          end
        end
      end
    end
  end

  // Port-B bookkeeping survives preemption; it is dropped only once b_req is gone
  // and no B transaction is on the wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_next_addr_reg <= 24'd0;
      b_remain_reg    <= 9'd0;
      b_req_d_reg     <= 1'b0;
      b_done_reg      <= 1'b0;
    end else begin
      b_req_d_reg <= b_req;
      b_done_reg  <= 1'b0;
      if (b_byte) begin
        b_next_addr_reg <= b_next_addr_reg + 24'd1;
        b_remain_reg    <= b_remain_reg - 9'd1;
        if (b_remain_reg == 9'd1) b_done_reg <= 1'b1;
      end else if (!b_req && !b_busy) begin
        b_remain_reg <= 9'd0;
      end else if (b_req && !b_req_d_reg && (b_remain_reg == 9'd0)) begin
        b_next_addr_reg <= b_addr;
        b_remain_reg    <= (b_len == 9'd0) ? 9'd256 : b_len;
      end
    end
  end

  assign a_valid = a_valid_reg;
  assign a_data  = a_data_reg;
  assign b_valid = b_valid_reg;
  assign b_data  = b_data_reg;
  assign b_done  = b_done_reg;

endmodule
